fractal_sync_rx_arb: RTL and testbench

Round-robin arbiter that shares one downstream consumer between `N_PORTS` fractal-sync RX request FIFOs. Each RX FIFO exposes empty/element/pop. The block pops at most one request per cycle, registers it in a single-entry output stage with a valid/ready handshake, and tags it with the index of the source port. It sits between the RX datapaths of a synchronization node and the node's request processing logic (RF/TX path), replacing per-port point-to-point pop wiring.

---
 rtl/fractal_sync_pkg.sv | 22 ++
 rtl/fractal_sync_rr_arb.sv | 43 ++++
 rtl/fractal_sync_rx_arb.sv | 99 +++++++++
 tb/tb_fractal_sync_rx_arb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_sync_pkg.sv
// Shared request types and index-width helper for the fractal-sync RX arbitration path.
package fractal_sync_pkg;

  localparam int unsigned FSYNC_AGGR_W = 8;
  localparam int unsigned FSYNC_ID_W   = 8;

  typedef struct packed {
    logic [FSYNC_AGGR_W-1:0] aggr;
    logic [FSYNC_ID_W-1:0]   id;
  } fsync_sig_t;

  typedef struct packed {
    logic       sync;
    fsync_sig_t sig;
  } fsync_req_t;

  // A single port still needs a 1-bit index so src/ptr signals never collapse to zero width.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fractal_sync_rr_arb.sv
// Combinational rotating-priority selector: first requester at or after ptr_i, modulo N_PORTS.
// Zero latency, no state; the caller decides whether the grant is consumed.
module fractal_sync_rr_arb
  import fractal_sync_pkg::*;
#(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned IDX_W   = idx_width(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [N_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  logic [2*N_PORTS-1:0] req_dbl;
  logic [2*N_PORTS-1:0] req_msk;

  // Upper copy is never masked, so any request left of the pointer wraps to it.
  always_comb begin
    req_dbl = {req_i, req_i};
    for (int i = 0; i < 2 * N_PORTS; i++) begin
      req_msk[i] = req_dbl[i] && (i >= int'(ptr_i));
    end
  end

  always_comb begin
    idx_o = '0;
    for (int i = 2 * N_PORTS - 1; i >= 0; i--) begin
      if (req_msk[i]) begin
        idx_o = (i >= int'(N_PORTS)) ? IDX_W'(i - int'(N_PORTS)) : IDX_W'(i);
      end
    end
  end

  always_comb begin
    vld_o = |req_i;
    for (int p = 0; p < N_PORTS; p++) begin
      gnt_o[p] = vld_o && (idx_o == IDX_W'(p));
    end
  end

endmodule

// File: rtl/fractal_sync_rx_arb.sv
// Round-robin reader of N_PORTS RX FIFOs into one registered, source-tagged valid/ready stage.
// pop_o is combinational in the grant cycle, valid_o follows one cycle later; a stalled stage holds everything.
module fractal_sync_rx_arb #(
  parameter type         fsync_req_t = logic,
  parameter int unsigned N_PORTS     = 2,
  parameter int unsigned IDX_W       = fractal_sync_pkg::idx_width(N_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_PORTS-1:0]   empty_i,
  input  fsync_req_t           req_i [N_PORTS],
  output logic [N_PORTS-1:0]   pop_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output fsync_req_t           req_o,
  output logic [IDX_W-1:0]     src_o,
  output logic                 error_empty_pop_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PORTS - 1);

  logic               valid_q, valid_d;
  fsync_req_t         req_q, req_d;
  logic [IDX_W-1:0]   src_q, src_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               err_q, err_d;

  logic [N_PORTS-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               any_vld;
  logic               stage_free;
  logic               grant;
  fsync_req_t         req_sel;

  fractal_sync_rr_arb #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) i_rr_arb (
    .req_i (~empty_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (any_vld)
  );

  // Gating with rst_ni keeps the FIFOs untouched while the stage is held in reset.
  always_comb begin
    stage_free = !valid_q || ready_i;
    grant      = stage_free && any_vld && rst_ni;
    pop_o      = grant ? gnt : '0;
  end

  always_comb begin
    req_sel = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (gnt[p]) begin
        req_sel = req_i[p];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (stage_free) begin
      valid_d = any_vld;
    end
    if (grant) begin
      req_d = req_sel;
      src_d = gnt_idx;
      ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end
    err_d = err_q || (|(pop_o & empty_i));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      req_q   <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  assign valid_o           = valid_q;
  assign req_o             = req_q;
  assign src_o             = src_q;
  assign error_empty_pop_o = err_q;

endmodule

// File: tb/tb_fractal_sync_rx_arb.sv
// Directed bench for fractal_sync_rx_arb with four ports, a FIFO/arbiter model and an output scoreboard.
module tb_fractal_sync_rx_arb;
  import fractal_sync_pkg::*;

  localparam int NP = 4;

  typedef struct packed {
    fsync_req_t req;
    logic [1:0] src;
  } exp_t;

  logic         clk_i;
  logic         rst_ni;
  logic [NP-1:0] empty_i;
  fsync_req_t   req_i [NP];
  logic [NP-1:0] pop_o;
  logic         valid_o;
  logic         ready_i;
  fsync_req_t   req_o;
  logic [1:0]   src_o;
  logic         error_empty_pop_o;

  fractal_sync_rx_arb #(
    .fsync_req_t (fsync_req_t),
    .N_PORTS     (NP)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .empty_i           (empty_i),
    .req_i             (req_i),
    .pop_o             (pop_o),
    .valid_o           (valid_o),
    .ready_i           (ready_i),
    .req_o             (req_o),
    .src_o             (src_o),
    .error_empty_pop_o (error_empty_pop_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_tests = 0;
  int n_fail  = 0;

  fsync_req_t mem [NP][16];
  int         rd [NP];
  int         wr [NP];
  exp_t       sb [$];
  logic       m_valid;
  int         m_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input logic [7:0] id);
    fsync_req_t r;
    r.sync     = 1'($urandom_range(0, 1));
    r.sig.aggr = 8'($urandom);
    r.sig.id   = id;
    mem[p][wr[p] % 16] = r;
    wr[p]++;
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      empty_i[p] = (wr[p] == rd[p]);
      req_i[p]   = (wr[p] == rd[p]) ? fsync_req_t'(0) : mem[p][rd[p] % 16];
    end
  endtask

  // One clock: drive FIFO heads, check pop/output against the model, advance model, cross the edge.
  task automatic tick(output logic [NP-1:0] pop_seen);
    logic [NP-1:0] exp_pop;
    logic          free;
    int            g;
    exp_t          e;
    drive_inputs();
    #1;
    pop_seen = pop_o;
    free = !m_valid || ready_i;
    g = -1;
    if (free) begin
      for (int k = 0; k < NP; k++) begin
        if (g < 0 && wr[(m_ptr + k) % NP] != rd[(m_ptr + k) % NP]) g = (m_ptr + k) % NP;
      end
    end
    exp_pop = (g >= 0) ? NP'(1 << g) : '0;
    chk("pop", 64'(pop_o), 64'(exp_pop));
    chk("valid", 64'(valid_o), 64'(m_valid));
    if (m_valid) begin
      chk("sb_has_entry", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        chk("req", 64'(req_o), 64'(sb[0].req));
        chk("src", 64'(src_o), 64'(sb[0].src));
        if (ready_i) void'(sb.pop_front());
      end
    end
    if (free) m_valid = (g >= 0);
    if (g >= 0) begin
      e.req = mem[g][rd[g] % 16];
      e.src = 2'(g);
      sb.push_back(e);
      rd[g]++;
      m_ptr = (g == NP - 1) ? 0 : g + 1;
    end
    @(posedge clk_i);
    #1;
    chk("ptr", 64'(dut.ptr_q), 64'(m_ptr));
    chk("err", 64'(error_empty_pop_o), 64'(0));
  endtask

  initial begin
    logic [NP-1:0] ps;
    for (int p = 0; p < NP; p++) begin
      rd[p] = 0;
      wr[p] = 0;
    end
    m_valid = 1'b0;
    m_ptr   = 0;
    rst_ni  = 1'b0;
    ready_i = 1'b0;
    drive_inputs();
    #2;
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_req", 64'(req_o), 64'(0));
    chk("rst_src", 64'(src_o), 64'(0));
    chk("rst_pop", 64'(pop_o), 64'(0));
    chk("rst_err", 64'(error_empty_pop_o), 64'(0));
    chk("rst_ptr", 64'(dut.ptr_q), 64'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Single request on port 0
    ready_i = 1'b1;
    push(0, 8'd5);
    tick(ps);
    chk("single_pop", 64'(ps), 64'(4'b0001));
    chk("single_valid", 64'(valid_o), 64'(1));
    chk("single_id", 64'(req_o.sig.id), 64'(5));
    chk("single_src", 64'(src_o), 64'(0));
    chk("single_ptr", 64'(dut.ptr_q), 64'(1));

    // Drain: accepted while all empty, valid drops, pointer stays
    tick(ps);
    chk("drain_pop", 64'(ps), 64'(0));
    chk("drain_valid", 64'(valid_o), 64'(0));
    chk("drain_ptr", 64'(dut.ptr_q), 64'(1));

    // Wrap-around: park pointer at 3, then ports 0 and 2 compete
    push(2, 8'h20);
    tick(ps);
    chk("wrap_setup_ptr", 64'(dut.ptr_q), 64'(3));
    push(0, 8'h30);
    push(2, 8'h31);
    tick(ps);
    chk("wrap_gnt0", 64'(ps), 64'(4'b0001));
    chk("wrap_ptr", 64'(dut.ptr_q), 64'(1));
    tick(ps);
    chk("wrap_gnt2", 64'(ps), 64'(4'b0100));
    tick(ps);

    // Backpressure with all ports loaded
    for (int p = 0; p < NP; p++) begin
      for (int j = 0; j < 8; j++) push(p, 8'(8'h40 + p * 16 + j));
    end
    ready_i = 1'b0;
    tick(ps);
    for (int c = 0; c < 5; c++) begin
      tick(ps);
      chk("bp_pop", 64'(ps), 64'(0));
      chk("bp_valid", 64'(valid_o), 64'(1));
    end
    ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(ps);
      chk("bp_release_nobubble", 64'(ps != 0), 64'(1));
    end

    // Reset mid-stream with a held request
    ready_i = 1'b0;
    tick(ps);
    chk("rst_mid_pre_valid", 64'(valid_o), 64'(1));
    rst_ni = 1'b0;
    drive_inputs();
    #1;
    chk("rst_mid_valid", 64'(valid_o), 64'(0));
    chk("rst_mid_req", 64'(req_o), 64'(0));
    chk("rst_mid_src", 64'(src_o), 64'(0));
    chk("rst_mid_pop", 64'(pop_o), 64'(0));
    chk("rst_mid_ptr", 64'(dut.ptr_q), 64'(0));
    m_valid = 1'b0;
    m_ptr   = 0;
    sb.delete();
    @(posedge clk_i);
    #1;
    chk("rst_mid_pop_hold", 64'(pop_o), 64'(0));
    rst_ni = 1'b1;

    // Fairness after reset: every port stays non-empty
    ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(ps);
      chk("fair_gnt", 64'(ps), 64'(4'b0001 << (k % 4)));
    end

    // Drain everything that remains, bounded
    for (int c = 0; c < 40; c++) tick(ps);
    chk("final_valid", 64'(valid_o), 64'(0));
    chk("final_sb_empty", 64'(sb.size()), 64'(0));
    chk("final_err", 64'(error_empty_pop_o), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
